// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter/rotator with valid/ready flow control.
// Stage k applies a shift of 2^k when its carried count bit is set, then
// registers the result. Ops: 00 ROL, 01 SLL, 10 SRA, 11 SRL.
module shift_pipe #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W:0]   occupancy
);

    typedef logic [WIDTH-1:0] word_t;

    // Data and valid exist for every stage; op, sign and the remaining count
    // are only needed by stages that still have a shift to apply, so the last
    // stage carries data only. The count is stored pre-shifted so bit 0 is
    // always the bit the next stage consumes.
    logic [CNT_W-1:0] valid_q, valid_d;
    word_t            data_q [CNT_W];
    word_t            data_d [CNT_W];
    logic [1:0]       op_q   [CNT_W-1];
    logic [1:0]       op_d   [CNT_W-1];
    logic [CNT_W-1:0] cnt_q  [CNT_W-1];
    logic [CNT_W-1:0] cnt_d  [CNT_W-1];
    logic [CNT_W-2:0] sign_q, sign_d;

    logic [CNT_W-1:0] ready;
    logic [CNT_W-1:0] src_valid;
    logic [CNT_W-1:0] src_sign;
    word_t            src_data [CNT_W];
    logic [1:0]       src_op   [CNT_W];
    logic [CNT_W-1:0] src_cnt  [CNT_W];

    function automatic word_t shift_by(input word_t d, input logic [1:0] op,
                                       input logic sign, input int unsigned s);
        word_t r;
        r = d;
        case (op)
            2'b00:   r = (d << s) | (d >> (WIDTH - s));
            2'b01:   r = d << s;
            2'b10:   r = (d >> s) | (sign ? ~({WIDTH{1'b1}} >> s) : '0);
            default: r = d >> s;
        endcase
        return r;
    endfunction

    // Stage k can take new data if it or any later stage is empty, or the
    // consumer is draining: the unrolled form of ready_k = !valid_k | ready_k+1.
    always_comb begin
        logic all_full;
        ready    = '0;
        all_full = 1'b1;
        for (int k = CNT_W - 1; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            ready[k] = out_ready | !all_full;
        end
    end

    // Input of each stage: the external operand for stage 0, the previous register otherwise.
    always_comb begin
        src_valid   = {valid_q[CNT_W-2:0], in_valid};
        src_sign    = {sign_q, in_data[WIDTH-1]};
        src_data[0] = in_data;
        src_op[0]   = in_op;
        src_cnt[0]  = in_cnt;
        for (int k = 1; k < CNT_W; k++) begin
            src_data[k] = data_q[k-1];
            src_op[k]   = op_q[k-1];
            src_cnt[k]  = cnt_q[k-1];
        end
    end

    // Next-state: load on ready with valid upstream, clear on ready with empty upstream, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        for (int k = 0; k < CNT_W; k++) begin
            if (ready[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    data_d[k] = src_cnt[k][0]
                              ? shift_by(src_data[k], src_op[k], src_sign[k], int'(1) << k)
                              : src_data[k];
                end
            end
        end
        for (int k = 0; k < CNT_W - 1; k++) begin
            if (ready[k] && src_valid[k]) begin
                op_d[k]   = src_op[k];
                cnt_d[k]  = src_cnt[k] >> 1;
                sign_d[k] = src_sign[k];
            end
        end
    end

    // Stage registers; reset discards every in-flight transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            sign_q  <= '0;
            for (int k = 0; k < CNT_W; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < CNT_W - 1; k++) begin
                op_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Occupancy is the number of full stage registers.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < CNT_W; k++) begin
            occupancy = occupancy + {{CNT_W{1'b0}}, valid_q[k]};
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[CNT_W-1];
    assign out_data  = data_q[CNT_W-1];

endmodule
